multi_frequency_counter: RTL
============================

MULTI_FREQUENCY_COUNTER -- requirements
Module: multi_frequency_counter

Interface
REQ-001 SHALL provide parameter CHANNELS, default 4: number of independent signal inputs, 1..8.
REQ-002 SHALL provide parameter COUNT_W, default 16: edge-counter and result width.
REQ-003 SHALL provide parameter PERIOD_W, default 12: gate-period register width.
REQ-004 SHALL provide parameter PERIOD_RESET, default 1000: period register value after reset, nonzero.
REQ-005 SHALL provide parameter DIGITS, default 2: number of multiplexed hex display digits, 1..4.
REQ-006 SHALL provide parameter REFRESH_W, default 10: display refresh divider width.
REQ-007 SHALL provide port clk  input  1  sole clock; all state changes on rising edge.
REQ-008 SHALL provide port reset_n  input  1  reset, synchronous, active-low.
REQ-009 SHALL provide port signal  input  CHANNELS  asynchronous measured signals.
REQ-010 SHALL provide port period_load  input  1  load strobe for period.
REQ-011 SHALL provide port period  input  PERIOD_W  gate window length in clk cycles.
REQ-012 SHALL provide port continuous  input  1  1 = back-to-back windows; 0 = single-shot.
REQ-013 SHALL provide port start  input  1  single-shot trigger.
REQ-014 SHALL provide port sel  input  max(1,clog2(CHANNELS))  channel shown on count_out/display.
REQ-015 SHALL provide port count_out  output  COUNT_W  result of channel sel.
REQ-016 SHALL provide port done  output  1  one-cycle pulse, results updated.
REQ-017 SHALL provide port overflow  output  CHANNELS  per-channel saturation flag of last window.
REQ-018 SHALL provide port segments  output  7  {g,f,e,d,c,b,a}, active-high.
REQ-019 SHALL provide port digit  output  DIGITS  one-hot active-high digit enable.

Function
REQ-020 SHALL pass each signal bit through a 2-flop synchroniser, then a rising-edge detector register; an input rising edge is counted on the 3rd clk edge after it is sampled.
REQ-021 SHALL implement states IDLE and COUNT; IDLE -> COUNT when continuous=1 or start=1, with gate counter and edge counters cleared; edges in IDLE ignored.
REQ-022 SHALL increment the gate counter once per COUNT cycle; window length is exactly period cycles.
REQ-023 SHALL, on the edge where gate counter equals period-1: copy all edge counters (including that cycle's edges) to results, copy saturation flags to overflow, clear edge counters and gate counter, assert done for the following cycle only, go to COUNT if continuous=1 else IDLE.
REQ-024 SHALL have zero dead cycles between windows in continuous mode; an edge in a window's first cycle counts in the new window.
REQ-025 SHALL saturate each edge counter at 2^COUNT_W-1 and set that channel's internal sticky flag for the window.
REQ-026 SHALL, when period_load=1, load period into the period register; if period=0 the load SHALL be ignored.
REQ-027 SHALL, on any accepted load while in COUNT, abort the window: go to IDLE, clear counters, no done, results unchanged.
REQ-028 SHALL ignore start while in COUNT; continuous deasserted mid-window lets the window complete, then IDLE.
REQ-029 SHALL drive count_out combinationally as result[sel]; sel >= CHANNELS SHALL yield 0.
REQ-030 SHALL advance the display digit index each time the free-running REFRESH_W-bit counter wraps, index 0..DIGITS-1 cyclic; digit[i]=1 for index i.
REQ-031 SHALL show hex nibble i of result[sel] on digit i using standard 0-F patterns (0 = 0111111, A = 1110111); if overflow[sel]=1, every digit SHALL show dash 1000000.

Reset
REQ-032 SHALL, on clk edge with reset_n=0: state IDLE, period register PERIOD_RESET, all counters/results 0, done 0, overflow 0, digit index 0, refresh counter 0.
REQ-033 SHALL present after reset: count_out 0, digit 1 (bit 0), segments 0111111.
REQ-034 SHALL let reset_n=0 mid-window override all other inputs, discarding the window without done.

Verification
REQ-035 SHALL cover: period=100, continuous=1, signal[0] period 10 cycles -> done every 100 cycles, result[0]=10 from second window on.
REQ-036 SHALL cover: COUNT_W=4, signal[1] toggling every cycle, period=100 -> result[1]=15, overflow[1]=1, sel=1 shows dashes on all digits.
REQ-037 SHALL cover: continuous=0, period=50, one start pulse -> exactly one done, 50 cycles after entering COUNT, then IDLE with no further done.
REQ-038 SHALL cover: period_load with period=20 at cycle 30 of a 100-cycle window -> no done, IDLE; later load of period=0 leaves period at 20.
REQ-039 SHALL cover: result[2]=0x3A, sel=2, DIGITS=2 -> digit alternates 01/10 every 2^REFRESH_W cycles, segments 1110111 with digit=01, 1001111 with digit=10.
REQ-040 SHALL cover: reset_n=0 for one cycle mid-window -> next cycle all outputs at REQ-032/033 values.

Source files
------------

// File: rtl/multi_frequency_counter.sv
// Multi-channel gated edge counter with single-shot/continuous windows,
// selectable result readout and a multiplexed 7-segment hex display.
module multi_frequency_counter #(
    parameter int CHANNELS     = 4,
    parameter int COUNT_W      = 16,
    parameter int PERIOD_W     = 12,
    parameter int PERIOD_RESET = 1000,
    parameter int DIGITS       = 2,
    parameter int REFRESH_W    = 10
) (
    input  logic                                                 clk,
    input  logic                                                 reset_n,
    input  logic [CHANNELS-1:0]                                  signal,
    input  logic                                                 period_load,
    input  logic [PERIOD_W-1:0]                                  period,
    input  logic                                                 continuous,
    input  logic                                                 start,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]   sel,
    output logic [COUNT_W-1:0]                                   count_out,
    output logic                                                 done,
    output logic [CHANNELS-1:0]                                  overflow,
    output logic [6:0]                                           segments,
    output logic [DIGITS-1:0]                                    digit
);

    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    typedef enum logic {IDLE, COUNT} state_t;

    state_t state, state_next;

    logic [PERIOD_W-1:0] period_reg;
    logic [PERIOD_W-1:0] gate;
    logic                load_ok;
    logic                last;
    logic                count_en;
    logic                capture;

    logic [CHANNELS-1:0] sync1, sync2, sync3;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] sat_hit;
    logic [CHANNELS-1:0] sticky;
    logic [COUNT_W-1:0]  edge_cnt [CHANNELS];
    logic [COUNT_W-1:0]  cnt_next [CHANNELS];
    logic [COUNT_W-1:0]  result   [CHANNELS];

    logic                ovf_sel;
    logic [REFRESH_W-1:0] refresh;
    logic [IDX_W-1:0]    digit_idx;
    logic [COUNT_W+15:0] padded;
    logic [3:0]          nibble;

    function automatic logic [6:0] hex_seg(input logic [3:0] value);
        case (value)
            4'h0: hex_seg = 7'b0111111;
            4'h1: hex_seg = 7'b0000110;
            4'h2: hex_seg = 7'b1011011;
            4'h3: hex_seg = 7'b1001111;
            4'h4: hex_seg = 7'b1100110;
            4'h5: hex_seg = 7'b1101101;
            4'h6: hex_seg = 7'b1111101;
            4'h7: hex_seg = 7'b0000111;
            4'h8: hex_seg = 7'b1111111;
            4'h9: hex_seg = 7'b1101111;
            4'hA: hex_seg = 7'b1110111;
            4'hB: hex_seg = 7'b1111100;
            4'hC: hex_seg = 7'b0111001;
            4'hD: hex_seg = 7'b1011110;
            4'hE: hex_seg = 7'b1111001;
            default: hex_seg = 7'b1110001;
        endcase
    endfunction

    assign load_ok = period_load && (period != '0);
    assign last    = (gate == period_reg - PERIOD_W'(1));

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (continuous || start) state_next = COUNT;
            COUNT: begin
                if (load_ok)                  state_next = IDLE;
                else if (last && !continuous) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A period load in COUNT aborts the window, so it also suppresses capture.
    always_comb begin
        count_en = (state == COUNT) && !load_ok;
        capture  = count_en && last;
    end

    always_comb begin
        rise = sync2 & ~sync3;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            sat_hit[i]  = rise[i] && (edge_cnt[i] == COUNT_MAX);
            cnt_next[i] = (rise[i] && !sat_hit[i]) ? edge_cnt[i] + COUNT_W'(1) : edge_cnt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1      <= '0;
            sync2      <= '0;
            sync3      <= '0;
            period_reg <= PERIOD_W'(PERIOD_RESET);
            gate       <= '0;
            done       <= 1'b0;
            overflow   <= '0;
            sticky     <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                edge_cnt[i] <= '0;
                result[i]   <= '0;
            end
        end else begin
            sync1 <= signal;
            sync2 <= sync1;
            sync3 <= sync2;
            if (load_ok) period_reg <= period;
            done <= capture;
            if (capture) begin
                for (int unsigned i = 0; i < CHANNELS; i++) begin
                    result[i]   <= cnt_next[i];
                    edge_cnt[i] <= '0;
                end
                overflow <= sticky | sat_hit;
                sticky   <= '0;
                gate     <= '0;
            end else if (count_en) begin
                for (int unsigned i = 0; i < CHANNELS; i++) begin
                    edge_cnt[i] <= cnt_next[i];
                end
                sticky <= sticky | sat_hit;
                gate   <= gate + PERIOD_W'(1);
            end else begin
                for (int unsigned i = 0; i < CHANNELS; i++) begin
                    edge_cnt[i] <= '0;
                end
                sticky <= '0;
                gate   <= '0;
            end
        end
    end

    always_comb begin
        count_out = '0;
        ovf_sel   = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (sel == SEL_W'(i)) begin
                count_out = result[i];
                ovf_sel   = overflow[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            refresh   <= '0;
            digit_idx <= '0;
        end else begin
            refresh <= refresh + REFRESH_W'(1);
            if (&refresh) begin
                digit_idx <= (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
            end
        end
    end

    // Zero padding lets digits beyond the result width show 0.
    always_comb begin
        padded   = {16'h0000, count_out};
        nibble   = padded[{digit_idx, 2'b00} +: 4];
        digit    = DIGITS'(1) << digit_idx;
        segments = ovf_sel ? 7'b1000000 : hex_seg(nibble);
    end

endmodule
